// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: reverse double-dabble over NSHIFT steps,
// followed by sign application with saturation to a signed 16-bit result.
module bcd_to_bin_seq #(
  parameter int unsigned NDIG   = 5,
  parameter int unsigned NSHIFT = 4 * NDIG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic              sign_in,
  output logic              busy,
  output logic              done,
  output logic [16:0]       mag_out,
  output logic [15:0]       bin_out,
  output logic              ovf,
  output logic              err
);

  localparam int unsigned W  = 4 * NDIG;
  localparam int unsigned CW = $clog2(NSHIFT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SHIFT = 3'd2,
    SIGN  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        bcd_q, bcd_d;
  logic [NSHIFT-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                sign_q, sign_d;
  logic [16:0]         mag_q, mag_d;
  logic [15:0]         bin_q, bin_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  logic [W+NSHIFT-1:0] sh;
  logic [W-1:0]        step_bcd;
  logic [NSHIFT-1:0]   step_acc;
  logic                bad_digit;
  logic [16:0]         mag_now;
  logic [16:0]         neg_mag;

  // One reverse double-dabble step on the current registers.
  always_comb begin
    sh       = {bcd_q, acc_q} >> 1;
    step_bcd = sh[W+NSHIFT-1:NSHIFT];
    step_acc = sh[NSHIFT-1:0];
    for (int unsigned d = 0; d < NDIG; d++) begin
      if (step_bcd[4*d+3]) step_bcd[4*d +: 4] = step_bcd[4*d +: 4] - 4'd3;
    end
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned d = 0; d < NDIG; d++) begin
      if (bcd_q[4*d +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // The accumulator is NSHIFT wide so every shifted-out bit lands in place;
  // the magnitude never exceeds 17 bits.
  assign mag_now = 17'(acc_q);
  assign neg_mag = 17'd0 - mag_now;

  // CHECK performs the first shift step on valid input, and the done pulse is
  // registered on leaving DONE; this keeps the valid path at 22 cycles, the
  // error path at 2 and lets a held start restart every 23 cycles.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = bcd_in;
          sign_d  = sign_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (bad_digit) begin
          err_d   = 1'b1;
          ovf_d   = 1'b0;
          state_d = DONE;
        end else begin
          err_d   = 1'b0;
          bcd_d   = step_bcd;
          acc_d   = step_acc;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = step_bcd;
        acc_d = step_acc;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NSHIFT - 1)) state_d = SIGN;
      end
      SIGN: begin
        mag_d = mag_now;
        if (!sign_q) begin
          if (mag_now > 17'd32767) begin
            bin_d = 16'h7FFF;
            ovf_d = 1'b1;
          end else begin
            bin_d = mag_now[15:0];
            ovf_d = 1'b0;
          end
        end else if (mag_now > 17'd32768) begin
          bin_d = 16'h8000;
          ovf_d = 1'b1;
        end else begin
          bin_d = (mag_now == 17'd0) ? 16'h0000 : neg_mag[15:0];
          ovf_d = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      bin_q   <= bin_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q == CHECK) || (state_q == SHIFT) || (state_q == SIGN);
  assign done    = done_q;
  assign mag_out = mag_q;
  assign bin_out = bin_q;
  assign ovf     = ovf_q;
  assign err     = err_q;

endmodule

// File: doc/bcd_to_bin_seq.md
BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
REQ-001 Parameter NDIG, default 5: number of BCD digits accepted.
REQ-002 Parameter NSHIFT, default 20 (4*NDIG): shift iterations per conversion.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1: sole clock, rising edge.
- rst_n  in  1: asynchronous active-low reset.
REQ-004 start  in  1: conversion request, sampled in IDLE only.
REQ-005 bcd_in  in  20: five BCD digits; [3:0] is units, [19:16] is ten-thousands.
REQ-006 sign_in  in  1: 1 means the value is negative.
REQ-007 busy  out  1: conversion in progress.
REQ-008 done  out  1: one-cycle completion pulse.
REQ-009 mag_out  out  17: unsigned binary magnitude, 0..99999.
REQ-010 bin_out  out  16: signed two's-complement result, saturated.
REQ-011 ovf  out  1: magnitude outside the signed 16-bit range.
REQ-012 err  out  1: an input digit is greater than 9.

Function
REQ-013 States SHALL be IDLE, CHECK, SHIFT, SIGN and DONE, fully encoded; any illegal encoding SHALL return to IDLE.
REQ-014 IDLE with start=1 at an edge SHALL load bcd_in and sign_in into internal registers, clear the 17-bit accumulator and the shift counter, and go to CHECK. start=1 in any other state SHALL be ignored.
REQ-015 CHECK SHALL set err=1, leave mag_out and bin_out unchanged, clear ovf, and go to DONE if any digit is greater than 9. Otherwise it SHALL set err=0 and go to SHIFT.
REQ-016 Each SHIFT cycle SHALL perform one reverse double-dabble step:
- Shift {bcd_reg, acc} right by 1.
- Then subtract 3 from every 4-bit digit of bcd_reg that is 8 or more.
- Increment the counter.
REQ-017 SHIFT SHALL run exactly NSHIFT cycles (counter 0..19), then go to SIGN.
REQ-018 SIGN SHALL register mag_out = acc and compute the signed result:
- Positive, magnitude at most 32767: bin_out = magnitude.
- Negative, magnitude at most 32768: bin_out = two's complement (the 17-bit negation, truncated to 16 bits).
- Magnitude 0 with sign_in=1: bin_out = 0 (no negative zero).
- Out of range: bin_out saturates to 16'h7FFF (positive) or 16'h8000 (negative), ovf=1; otherwise ovf=0.
- Then go to DONE.
REQ-019 DONE SHALL drive done=1 for exactly one cycle, then go to IDLE.
REQ-020 busy SHALL be 1 exactly while in CHECK, SHIFT or SIGN; done and busy SHALL never both be 1.
REQ-021 Latency, with start sampled at edge E0:
- Valid input: done is high from E22 to E23 (done rises 22 cycles after E0).
- Invalid input: done is high from E2 to E3.
REQ-022 A new start SHALL be accepted no earlier than the edge after done falls; start held high SHALL produce back-to-back conversions, one every 23 cycles.
REQ-023 mag_out, bin_out, ovf and err SHALL hold their values until the next SIGN or CHECK-error update.
REQ-024 Inputs bcd_in and sign_in SHALL be don't-care after the loading edge.

Reset
REQ-025 While rst_n=0, the block SHALL immediately force the state to IDLE and all of busy, done, mag_out, bin_out, ovf, err, the counter and the internal registers to 0.
REQ-026 Reset asserted mid-conversion SHALL abort the conversion without a done pulse.
REQ-027 The first start SHALL be accepted at the first rising edge after rst_n rises.

Verification
REQ-028 bcd_in=20'h15625, sign_in=0, start pulse -> done rises 22 cycles after the start edge; mag_out=17'h03D09, bin_out=16'h3D09, ovf=0, err=0.
REQ-029 bcd_in=20'h15625, sign_in=1 -> bin_out=16'hC2F7, mag_out=17'h03D09, ovf=0.
REQ-030 Range boundaries:
- 20'h32768, sign_in=1 -> bin_out=16'h8000, ovf=0.
- 20'h32768, sign_in=0 -> bin_out=16'h7FFF, ovf=1.
- 20'h99999, sign_in=0 -> mag_out=17'h1869F, bin_out=16'h7FFF, ovf=1.
REQ-031 bcd_in=20'h1A000 -> done rises 2 cycles after the start edge with err=1; bin_out keeps its previous value.
REQ-032 bcd_in=20'h00000, sign_in=1 -> bin_out=16'h0000, ovf=0; then start held high for 60 cycles -> exactly two done pulses, 23 cycles apart, with busy low on each done cycle.
REQ-033 rst_n driven low at SHIFT counter 10 -> all outputs 0 immediately and no done pulse; after release, a new 20'h00042 conversion -> bin_out=16'h002A.
